// File: rtl/limber_gnrl_fifo_wr_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : limber_gnrl_fifo_wr_arb_pkg
// Brief    : Shared helpers for the FIFO write-port arbiter family.
// Revision : 1.0 - initial release
// ============================================================================
package limber_gnrl_fifo_wr_arb_pkg;

  // Next round-robin position after idx, wrapping at n.
  function automatic int rr_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/limber_gnrl_rr_pick.sv
`default_nettype none
// ============================================================================
// Module   : limber_gnrl_rr_pick
// Brief    : Combinational round-robin picker. Chooses the first set request
//            at or above ptr (modulo N); outputs one-hot grant and its index.
// Revision : 1.0 - initial release
// ============================================================================
module limber_gnrl_rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx
);

  // Rotate requests so that ptr lands at bit 0, find the lowest set bit,
  // then rotate the one-hot result back into place.
  logic [2*N-1:0] dbl_req;
  logic [N-1:0]   rot;
  logic [N-1:0]   hit;
  logic [2*N-1:0] dbl_hit;
  logic [IW-1:0]  enc [N+1];

  assign dbl_req = {req, req};
  assign rot     = N'(dbl_req >> ptr);

  generate
    for (genvar j = 0; j < N; j++) begin : g_first
      if (j == 0) begin : g_lsb
        assign hit[j] = rot[j];
      end else begin : g_upper
        assign hit[j] = rot[j] & ~(|rot[j-1:0]);
      end
    end
  endgenerate

  assign dbl_hit = {hit, hit};
  assign gnt     = N'((dbl_hit << ptr) >> N);

  // One-hot to binary: OR together the index of whichever bit is set.
  assign enc[0] = '0;
  generate
    for (genvar i = 0; i < N; i++) begin : g_enc
      assign enc[i+1] = enc[i] | (gnt[i] ? IW'(i) : '0);
    end
  endgenerate
  assign idx = enc[N];

endmodule
`default_nettype wire

// File: rtl/limber_gnrl_fifo_wr_arb.sv
`default_nettype none
// ============================================================================
// Module   : limber_gnrl_fifo_wr_arb
// Brief    : Round-robin arbiter sharing one async-FIFO write port among N
//            requesters. Grants bounded bursts, tags each word with the
//            requester ID and honours the FIFO full flag.
// Revision : 1.0 - initial release
// ============================================================================
module limber_gnrl_fifo_wr_arb
  import limber_gnrl_fifo_wr_arb_pkg::*;
#(
  parameter int N        = 4,
  parameter int DW       = 8,
  parameter int IW       = $clog2(N),
  parameter int MAXBURST = 4,
  parameter int CW       = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N-1:0]      req_valid,
  input  logic [N*DW-1:0]   req_data,
  input  logic [N-1:0]      req_last,
  output logic [N-1:0]      req_ready,
  input  logic              fifo_full,
  output logic [IW+DW-1:0]  fifo_din,
  output logic              fifo_wen,
  output logic [N-1:0]      gnt,
  output logic              busy
);

  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_BURST = 1'b1;

  logic          state_q;
  logic [N-1:0]  gnt_q;
  logic [IW-1:0] idx_q;
  logic [IW-1:0] ptr_q;
  logic [CW-1:0] beat_q;

  logic [N-1:0]  pick_gnt;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] ptr_d;
  logic [DW-1:0] data_arr [N];

  logic in_burst;
  logic cur_valid;
  logic cur_last;
  logic fire;
  logic beat_end;
  logic release_burst;

  limber_gnrl_rr_pick #(
    .N  (N),
    .IW (IW)
  ) u_pick (
    .req (req_valid),
    .ptr (ptr_q),
    .gnt (pick_gnt),
    .idx (pick_idx)
  );

  generate
    for (genvar i = 0; i < N; i++) begin : g_unpack
      assign data_arr[i] = req_data[i*DW +: DW];
    end
  endgenerate

  assign in_burst  = (state_q == ST_BURST);
  assign cur_valid = req_valid[idx_q];
  assign cur_last  = req_last[idx_q];
  assign fire      = in_burst & cur_valid & ~fifo_full;
  assign beat_end  = (beat_q == CW'(MAXBURST - 1));
  // A burst ends on its last or MAXBURST-th beat, or at once if the owner
  // withdraws valid; a full FIFO alone never ends it.
  assign release_burst = in_burst & (~cur_valid | (fire & (cur_last | beat_end)));
  assign ptr_d     = IW'(rr_inc(int'(idx_q), N));

  // Arbitration FSM: grant in IDLE, count beats and release in BURST.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      gnt_q   <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      beat_q  <= '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (|req_valid) begin
            state_q <= ST_BURST;
            gnt_q   <= pick_gnt;
            idx_q   <= pick_idx;
            beat_q  <= '0;
          end
        end
        ST_BURST: begin
          if (release_burst) begin
            state_q <= ST_IDLE;
            gnt_q   <= '0;
            beat_q  <= '0;
            ptr_q   <= ptr_d;
          end else if (fire) begin
            beat_q  <= beat_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Write-side outputs are combinational and held at zero during reset.
  assign busy      = in_burst;
  assign gnt       = gnt_q;
  assign fifo_wen  = ~rst & fire;
  assign req_ready = (~rst & in_burst & ~fifo_full) ? gnt_q : '0;
  assign fifo_din  = (~rst & in_burst) ? {idx_q, data_arr[idx_q]} : '0;

endmodule
`default_nettype wire

// File: doc/limber_gnrl_fifo_wr_arb.md
# limber_gnrl_fifo_wr_arb

Round-robin write-port arbiter that shares the single write port of an async FIFO among N requesters in the FIFO's write-clock domain. Each requester offers words with a valid/ready handshake; the arbiter grants one requester at a time for a bounded burst. It tags each word with the requester ID and writes it while honouring the FIFO's write-side full flag. It sits directly in front of the FIFO write port (din/wen/full) in the producer clock domain.

## Interface
- N, 4, number of requesters (2..16)
- DW, 8, payload width per requester
- IW, $clog2(N), requester ID width
- MAXBURST, 4, max beats per grant (1..2^CW)
- CW, 3, beat counter width; must satisfy 2^CW >= MAXBURST

- clk  in  1  FIFO write clock
- rst  in  1  synchronous, active-high reset
- req_valid  in  N  per-requester word valid
- req_data  in  N*DW  packed payloads, requester i at [i*DW +: DW]
- req_last  in  N  per-requester end-of-burst marker, qualified by req_valid
- req_ready  out  N  per-requester accept; a beat transfers when valid & ready
- fifo_full  in  1  FIFO write-side full flag
- fifo_din  out  IW+DW  {granted ID, granted payload}
- fifo_wen  out  1  FIFO write enable
- gnt  out  N  one-hot current grant, all-zero when idle
- busy  out  1  burst in progress

## Operation
- States: IDLE, BURST.
- IDLE: if any req_valid is high, pick the first set bit scanning upward from the priority pointer `ptr`, with modulo-N wrap. Register the one-hot grant into gnt, clear beat_cnt, and go to BURST. No beat transfers in IDLE.
- BURST, with granted index g:
  - Fire condition: fire = req_valid[g] & ~fifo_full.
  - req_ready[g] = ~fifo_full. All other req_ready bits are 0.
  - fifo_wen = fire.
  - fifo_din = {g, req_data[g]}.
- On fire: beat_cnt increments. If req_last[g], or beat_cnt == MAXBURST-1, release the grant.
- If req_valid[g] is low, release immediately with no write. An abandoned burst is legal.
- If fifo_full is high and req_valid[g] is high: hold the grant, do not write, and do not advance beat_cnt.
- On release: state goes to IDLE, gnt to 0, beat_cnt to 0, and ptr to (g+1) mod N.
- fifo_din is 0 while in IDLE.
- busy = (state == BURST).
- The ID field carries g zero-extended to IW bits.

## Timing
- Reset, effective at the first clk edge with rst high:
  - state IDLE, gnt 0, ptr 0, beat_cnt 0.
  - req_ready, fifo_wen and fifo_din are all 0, and are forced to 0 combinationally while rst is high.
- Arbitration latency: the grant is visible 1 cycle after req_valid is sampled in IDLE. The first write can occur in that cycle.
- Outputs req_ready, fifo_wen and fifo_din are combinational from the registered state and from fifo_full / req_valid / req_data. No output registers.
- Throughput: one-cycle bubble per grant, so a burst of B beats with no backpressure takes B+1 cycles.
- fifo_full rising in the same cycle as a last beat: the beat does not transfer, and the grant holds until the beat is written.
- A requester must keep req_data and req_last stable while req_valid is high and ready is low.
- Reset mid-burst: no write in the reset cycle. The arbiter is in IDLE with ptr 0 on the next cycle, and any partial burst is abandoned.
- Requesters that are not granted see ready 0 regardless of fifo_full.

## Structure
- No shared package needed.
- State encodings ST_IDLE/ST_BURST are localparams in the module.
- Sub-module limber_gnrl_rr_pick #(N): a combinational round-robin picker with inputs req[N-1:0] and ptr[IW-1:0], and outputs a one-hot grant and a binary index. It is reusable by other arbiters in the library.
- Flops: state, gnt/index, ptr and beat_cnt, all with synchronous reset.

## Test plan
- Single requester, N=4, MAXBURST=4. req 0 streams 6 words 0x10..0x15 with last on the 6th.
  - fifo writes: {0,0x10}..{0,0x13}, a 1-cycle gap, then {0,0x14},{0,0x15}.
  - gnt cycles 0001 / 0000 / 0001.
- All 4 requesters valid continuously, single-beat bursts (last=1). Grant order 0,1,2,3,0,…; each fifo write carries ID matching the grant; one write every 2 cycles.
- fifo_full asserted for 3 cycles mid-burst of req 2. No fifo_wen, req_ready[2] low, gnt stays 0100, beat_cnt frozen. The burst resumes and completes with all words written exactly once, in order.
- req 1 drops valid after 2 of 4 beats. Release with no extra write; the next grant goes to the lowest valid index at or above 2.
- rst asserted during the 3rd beat of a burst. fifo_wen 0 in that cycle; the next cycle shows gnt 0, busy 0, ptr 0. With req 3 and req 0 both valid, req 0 wins.
- fifo_full and last beat in the same cycle. No write that cycle; the word is written exactly once when full deasserts, then release.
